// File: rtl/controle_multiciclo_if.sv
// Control bundle between the multicycle FSM and the MIPS datapath.
// master: FSM side (takes IR fields/mem_ready, drives controls); slave: datapath side.
interface controle_multiciclo_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       instr_done;
  logic       invalid;
  logic [3:0] state;

  modport master (
    input  opcode, func, mem_ready,
    output PCWrite, PCWriteCond, IorD,
    output MemRead, MemWrite, IRWrite,
    output RegDst, MemtoReg, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp, PCSrc,
    output instr_done, invalid, state
  );

  modport slave (
    output opcode, func, mem_ready,
    input  PCWrite, PCWriteCond, IorD,
    input  MemRead, MemWrite, IRWrite,
    input  RegDst, MemtoReg, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSrc,
    input  instr_done, invalid, state
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/mem/writeback.
// Ports: clk, reset_n (async low), bus (controle_multiciclo_if.master).
module controle_multiciclo (
  input logic                   clk,
  input logic                   reset_n,
  controle_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12,
    S_JR       = 4'd13,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  state_t st, nx;
  logic   lw_q, lw_d;

  logic       pcw, pcwc, iord;
  logic       mrd, mwr, irw;
  logic       rdst, m2r, rw;
  logic       asa;
  logic [1:0] asb, aop, psrc;
  logic       done, inv;

  logic is_mem, is_jr, is_r;
  logic is_beq, is_addi, is_j;

  assign is_mem  = (bus.opcode == OP_LW)
                 | (bus.opcode == OP_SW);
  assign is_jr   = (bus.opcode == OP_R)
                 & (bus.func == FN_JR);
  assign is_r    = (bus.opcode == OP_R)
                 & (bus.func != FN_JR);
  assign is_beq  = bus.opcode == OP_BEQ;
  assign is_addi = bus.opcode == OP_ADDI;
  assign is_j    = bus.opcode == OP_J;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st   <= S_IDLE;
      lw_q <= 1'b0;
    end else begin
      st   <= nx;
      lw_q <= lw_d;
    end
  end

  always_comb begin
    nx   = st;
    lw_d = lw_q;
    pcw  = 1'b0;
    pcwc = 1'b0;
    iord = 1'b0;
    mrd  = 1'b0;
    mwr  = 1'b0;
    irw  = 1'b0;
    rdst = 1'b0;
    m2r  = 1'b0;
    rw   = 1'b0;
    asa  = 1'b0;
    asb  = 2'b00;
    aop  = 2'b00;
    psrc = 2'b00;
    done = 1'b0;
    inv  = 1'b0;
    unique case (st)
      S_IDLE: nx = S_FETCH;
      S_FETCH: begin
        mrd = 1'b1;
        asb = 2'b01;
        irw = bus.mem_ready;
        pcw = bus.mem_ready;
        if (bus.mem_ready) nx = S_DECODE;
      end
      S_DECODE: begin
        asb  = 2'b11;
        // remember lw vs sw; IR may not hold it later
        lw_d = bus.opcode == OP_LW;
        unique case (1'b1)
          is_mem:  nx = S_MEMADR;
          is_jr:   nx = S_JR;
          is_r:    nx = S_EXECUTE;
          is_beq:  nx = S_BRANCH;
          is_addi: nx = S_ADDIEX;
          is_j:    nx = S_JUMP;
          default: nx = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        asa = 1'b1;
        asb = 2'b10;
        nx  = lw_q ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mrd  = 1'b1;
        iord = 1'b1;
        if (bus.mem_ready) nx = S_MEMWB;
      end
      S_MEMWB: begin
        rw   = 1'b1;
        m2r  = 1'b1;
        done = 1'b1;
        nx   = S_FETCH;
      end
      S_MEMWRITE: begin
        mwr  = 1'b1;
        iord = 1'b1;
        done = bus.mem_ready;
        if (bus.mem_ready) nx = S_FETCH;
      end
      S_EXECUTE: begin
        asa = 1'b1;
        aop = 2'b10;
        nx  = S_ALUWB;
      end
      S_ALUWB: begin
        rw   = 1'b1;
        rdst = 1'b1;
        done = 1'b1;
        nx   = S_FETCH;
      end
      S_BRANCH: begin
        asa  = 1'b1;
        aop  = 2'b01;
        pcwc = 1'b1;
        psrc = 2'b01;
        done = 1'b1;
        nx   = S_FETCH;
      end
      S_ADDIEX: begin
        asa = 1'b1;
        asb = 2'b10;
        nx  = S_ADDIWB;
      end
      S_ADDIWB: begin
        rw   = 1'b1;
        done = 1'b1;
        nx   = S_FETCH;
      end
      S_JUMP: begin
        pcw  = 1'b1;
        psrc = 2'b10;
        done = 1'b1;
        nx   = S_FETCH;
      end
      S_JR: begin
        pcw  = 1'b1;
        psrc = 2'b11;
        done = 1'b1;
        nx   = S_FETCH;
      end
      S_ERROR: inv = 1'b1;
      default: nx = S_ERROR;
    endcase
  end

  assign bus.PCWrite     = pcw;
  assign bus.PCWriteCond = pcwc;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mrd;
  assign bus.MemWrite    = mwr;
  assign bus.IRWrite     = irw;
  assign bus.RegDst      = rdst;
  assign bus.MemtoReg    = m2r;
  assign bus.RegWrite    = rw;
  assign bus.ALUSrcA     = asa;
  assign bus.ALUSrcB     = asb;
  assign bus.ALUOp       = aop;
  assign bus.PCSrc       = psrc;
  assign bus.instr_done  = done;
  assign bus.invalid     = inv;
  assign bus.state       = st;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized bench for controle_multiciclo against a per-instruction
// cycle-sequence model built from the instruction-class rules.
module tb_controle_multiciclo;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  controle_multiciclo_if bus();

  controle_multiciclo dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] e;
    logic        mr;
    logic        scr;
  } cyc_t;

  cyc_t q[$];
  int   bt[7] = '{5, 4, 4, 3, 4, 3, 3};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] dutv();
    return {bus.state, bus.PCWrite, bus.PCWriteCond,
            bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.RegDst, bus.MemtoReg,
            bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUOp, bus.PCSrc, bus.instr_done,
            bus.invalid};
  endfunction

  // b = {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,
  //      IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA}
  function automatic logic [21:0] v(
    input logic [3:0] s,
    input logic [9:0] b,
    input logic [1:0] asb,
    input logic [1:0] op,
    input logic [1:0] src,
    input logic       d,
    input logic       inv);
    return {s, b, asb, op, src, d, inv};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [21:0] e,
                      input logic mr,
                      input logic s);
    cyc_t c;
    c.e   = e;
    c.mr  = mr;
    c.scr = s;
    q.push_back(c);
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1 chk("rst_now", 32'(dutv()), 32'd0);
    @(negedge clk);
    bus.mem_ready = rb();
    #1 chk("rst_hold", 32'(dutv()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.mem_ready = rb();
    #1 chk("rst_idle", 32'(dutv()), 32'd0);
  endtask

  function automatic logic [5:0] bad_op();
    logic [5:0] o;
    do o = 6'($urandom);
    while (o == 6'd0 || o == 6'd2 || o == 6'd4 ||
           o == 6'd8 || o == 6'd35 || o == 6'd43);
    return o;
  endfunction

  // cls: 0 lw 1 sw 2 R 3 beq 4 addi 5 j 6 jr 7 bad
  task automatic do_instr(input int cls,
                          input int fsi,
                          input int msi,
                          input int ab);
    int fs;
    int ms;
    int lat;
    fs = (fsi < 0) ? $urandom_range(0, 2) : fsi;
    ms = (msi < 0) ? $urandom_range(0, 3) : msi;
    q.delete();
    case (cls)
      0: bus.opcode = 6'b100011;
      1: bus.opcode = 6'b101011;
      2, 6: bus.opcode = 6'b000000;
      3: bus.opcode = 6'b000100;
      4: bus.opcode = 6'b001000;
      5: bus.opcode = 6'b000010;
      default: bus.opcode = bad_op();
    endcase
    bus.func = 6'($urandom);
    if (cls == 6) bus.func = 6'b001000;
    else if (bus.func == 6'b001000) bus.func = 6'b100000;

    for (int i = 0; i < fs; i++)
      push(v(1, 10'b0001000000, 2'b01, 2'b00, 2'b00, 0, 0), 0, 0);
    push(v(1, 10'b1001010000, 2'b01, 2'b00, 2'b00, 0, 0), 1, 0);
    push(v(2, 10'b0, 2'b11, 2'b00, 2'b00, 0, 0), rb(), 0);
    case (cls)
      0: begin
        push(v(3, 10'b0000000001, 2'b10, 2'b00, 2'b00, 0, 0), rb(), 1);
        for (int i = 0; i < ms; i++)
          push(v(4, 10'b0011000000, 2'b00, 2'b00, 2'b00, 0, 0), 0, 1);
        push(v(4, 10'b0011000000, 2'b00, 2'b00, 2'b00, 0, 0), 1, 1);
        push(v(5, 10'b0000000110, 2'b00, 2'b00, 2'b00, 1, 0), rb(), 1);
      end
      1: begin
        push(v(3, 10'b0000000001, 2'b10, 2'b00, 2'b00, 0, 0), rb(), 1);
        for (int i = 0; i < ms; i++)
          push(v(6, 10'b0010100000, 2'b00, 2'b00, 2'b00, 0, 0), 0, 1);
        push(v(6, 10'b0010100000, 2'b00, 2'b00, 2'b00, 1, 0), 1, 1);
      end
      2: begin
        push(v(7, 10'b0000000001, 2'b00, 2'b10, 2'b00, 0, 0), rb(), 1);
        push(v(8, 10'b0000001010, 2'b00, 2'b00, 2'b00, 1, 0), rb(), 1);
      end
      3: push(v(9, 10'b0100000001, 2'b00, 2'b01, 2'b01, 1, 0), rb(), 1);
      4: begin
        push(v(10, 10'b0000000001, 2'b10, 2'b00, 2'b00, 0, 0), rb(), 1);
        push(v(11, 10'b0000000010, 2'b00, 2'b00, 2'b00, 1, 0), rb(), 1);
      end
      5: push(v(12, 10'b1000000000, 2'b00, 2'b00, 2'b10, 1, 0), rb(), 1);
      6: push(v(13, 10'b1000000000, 2'b00, 2'b00, 2'b11, 1, 0), rb(), 1);
      default:
        for (int i = 0; i < 20; i++)
          push(v(15, 10'b0, 2'b00, 2'b00, 2'b00, 0, 1), rb(), 1);
    endcase

    lat = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      bus.mem_ready = q[i].mr;
      if (q[i].scr) begin
        bus.opcode = 6'($urandom);
        bus.func   = 6'($urandom);
      end
      #1;
      chk($sformatf("cls%0d_cyc%0d", cls, i),
          32'(dutv()), 32'(q[i].e));
      if (lat == 0 && bus.instr_done) lat = i + 1;
      if (i == ab) begin
        do_reset();
        return;
      end
    end
    if (cls < 7)
      chk($sformatf("lat_cls%0d", cls), lat,
          bt[cls] + fs + ((cls < 2) ? ms : 0));
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'd0;
    bus.func      = 6'd0;
    do_reset();

    do_instr(2, 0, 0, -1);
    bus.func = 6'b100000;
    do_instr(0, 2, 3, -1);
    do_instr(3, 0, 0, -1);
    do_instr(5, 0, 0, -1);
    do_instr(6, 0, 0, -1);
    do_instr(1, -1, 3, -1);
    do_instr(4, -1, -1, -1);

    for (int n = 0; n < 60; n++)
      do_instr($urandom_range(0, 6), -1, -1, -1);

    // abort a lw while it waits in MEMREAD
    do_instr(0, 1, 3, 5);
    for (int n = 0; n < 10; n++)
      do_instr($urandom_range(0, 6), -1, -1, -1);

    do_instr(7, -1, -1, -1);
    do_reset();
    do_instr(2, -1, -1, -1);
    do_instr(0, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
